// File: rtl/mmio_arb_pkg.sv
// Shared types and defaults for the MMIO bus arbiter slice.
package mmio_arb_pkg;

  localparam int N_M_DEF    = 2;
  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Master index width; never zero so a one-master build still has a legal vector.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Master-side request bundle plus the FPro MMIO bus, shared by the arbiter and its neighbours.
interface mmio_bus_arbiter_if
  import mmio_arb_pkg::*;
#(
  parameter int N_M    = N_M_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Handshake: m_cs[i] is a valid that stays high (with stable wr/rd/lock/addr/data)
  // until the one-cycle m_ack[i] pulse, which is the only ready/done indication.
  logic [N_M-1:0]        m_cs;
  logic [N_M-1:0]        m_wr;
  logic [N_M-1:0]        m_rd;
  logic [N_M-1:0]        m_lock;
  logic [N_M*ADDR_W-1:0] m_addr;
  logic [N_M*DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0]     m_rd_data;
  logic [N_M-1:0]        m_ack;

  logic                  mmio_cs;
  logic                  mmio_wr;
  logic                  mmio_rd;
  logic [ADDR_W-1:0]     mmio_addr;
  logic [DATA_W-1:0]     mmio_wr_data;
  logic [DATA_W-1:0]     mmio_rd_data;

  modport master (
    output m_cs, m_wr, m_rd, m_lock, m_addr, m_wr_data,
    input  m_rd_data, m_ack
  );

  modport slave (
    input  m_cs, m_wr, m_rd, m_lock, m_addr, m_wr_data,
    output m_rd_data, m_ack,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data
  );

  modport mmio (
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data
  );

endinterface

// File: rtl/mmio_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module mmio_rr_pick
  import mmio_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter with per-master lock that shares one FPro MMIO bus among N_M masters.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int N_M      = N_M_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_TMO = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_bus_arbiter_if.slave      bus,
  output logic [$clog2(N_M)-1:0] grant_id,
  output logic                   locked,
  output logic [1:0]             state
);

  localparam int IDW = $clog2(N_M);
  localparam int TW  = $clog2(LOCK_TMO + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_ACK   = ACK;

  logic [1:0]        state_q;
  logic [N_M-1:0]    win_oh_q;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    owner;
  logic [TW-1:0]     lock_tmr;

  logic [N_M-1:0]    owner_mask;
  logic [N_M-1:0]    elig;
  logic [N_M-1:0]    pick_oh;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic              sel_wr;
  logic              sel_rd;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wr_data;

  // While a lock is held, only the owner may compete.
  assign owner_mask = {{(N_M-1){1'b0}}, 1'b1} << owner;
  assign elig       = locked ? (bus.m_cs & owner_mask) : bus.m_cs;

  mmio_rr_pick #(.N(N_M), .IDW(IDW)) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_wr      = bus.m_wr[pick_idx];
  assign sel_rd      = bus.m_rd[pick_idx];
  assign sel_lock    = bus.m_lock[pick_idx];
  assign sel_addr    = bus.m_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_wr_data = bus.m_wr_data[pick_idx*DATA_W +: DATA_W];

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      win_oh_q         <= '0;
      rr_ptr           <= '0;
      owner            <= '0;
      lock_tmr         <= '0;
      grant_id         <= '0;
      locked           <= 1'b0;
      bus.m_ack        <= '0;
      bus.m_rd_data    <= '0;
      bus.mmio_cs      <= 1'b0;
      bus.mmio_wr      <= 1'b0;
      bus.mmio_rd      <= 1'b0;
      bus.mmio_addr    <= '0;
      bus.mmio_wr_data <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            state_q          <= S_ISSUE;
            win_oh_q         <= pick_oh;
            grant_id         <= pick_idx;
            owner            <= pick_idx;
            locked           <= sel_lock;
            lock_tmr         <= '0;
            // A grant made under lock leaves the rotation where it was.
            if (!locked)
              rr_ptr <= (pick_idx == IDW'(N_M - 1)) ? '0 : pick_idx + 1'b1;
            // wr+rd together degrades to a write; neither strobe means no bus cycle.
            bus.mmio_cs      <= sel_wr | sel_rd;
            bus.mmio_wr      <= sel_wr;
            bus.mmio_rd      <= sel_rd & ~sel_wr;
            bus.mmio_addr    <= sel_addr;
            bus.mmio_wr_data <= sel_wr_data;
          end else if (locked) begin
            if (lock_tmr == TW'(LOCK_TMO - 1)) begin
              locked   <= 1'b0;
              lock_tmr <= '0;
            end else begin
              lock_tmr <= lock_tmr + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q          <= S_ACK;
          bus.m_ack        <= win_oh_q;
          bus.m_rd_data    <= bus.mmio_rd ? bus.mmio_rd_data : '0;
          bus.mmio_cs      <= 1'b0;
          bus.mmio_wr      <= 1'b0;
          bus.mmio_rd      <= 1'b0;
          bus.mmio_addr    <= '0;
          bus.mmio_wr_data <= '0;
        end
        S_ACK: begin
          state_q   <= S_IDLE;
          bus.m_ack <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: two masters, LOCK_TMO=4, small GPI/GPO slave model.
module tb_mmio_bus_arbiter;

  localparam int N_M      = 2;
  localparam int ADDR_W   = 21;
  localparam int DATA_W   = 32;
  localparam int LOCK_TMO = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] grant_id;
  logic       locked;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] led    = 8'h00;
  int         cs_cnt = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter_if #(.N_M(N_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mmio_bus_arbiter #(
    .N_M(N_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TMO(LOCK_TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .locked   (locked),
    .state    (state)
  );

  // Slave model: GPI at 0xC0 reads sw=0xA5, other addresses read a tagged pattern; GPO led at 0x80.
  always_comb
    bus.mmio_rd_data = (bus.mmio_addr == 21'h000C0) ? 32'h0000_00A5
                                                    : (32'hBEEF_0000 | 32'(bus.mmio_addr));

  always @(posedge clk) begin
    if (bus.mmio_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (bus.mmio_wr && bus.mmio_addr == 21'h00080) led <= bus.mmio_wr_data[7:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic wr, input logic rd, input logic lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.m_cs[m]   = 1'b1;
    bus.m_wr[m]   = wr;
    bus.m_rd[m]   = rd;
    bus.m_lock[m] = lock;
    bus.m_addr[m*ADDR_W +: ADDR_W]    = a;
    bus.m_wr_data[m*DATA_W +: DATA_W] = d;
  endtask

  task automatic drop_req(input int m);
    bus.m_cs[m]   = 1'b0;
    bus.m_wr[m]   = 1'b0;
    bus.m_rd[m]   = 1'b0;
    bus.m_lock[m] = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.m_cs      = '0;
    bus.m_wr      = '0;
    bus.m_rd      = '0;
    bus.m_lock    = '0;
    bus.m_addr    = '0;
    bus.m_wr_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (bus.mmio_cs !== 1'b0) begin n_err++; $display("FAIL rst_mmio_cs: got %b want 0", bus.mmio_cs); end
    n_cmp++; if (bus.mmio_addr !== 21'h0) begin n_err++; $display("FAIL rst_mmio_addr: got %h want 0", bus.mmio_addr); end
    n_cmp++; if (bus.m_ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", bus.m_ack); end
    n_cmp++; if (bus.m_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", bus.m_rd_data); end
    n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b want 0", locked); end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 1'b1, 1'b0, 21'h000C0, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.mmio_cs !== 1'b1 || bus.mmio_rd !== 1'b1 || bus.mmio_wr !== 1'b0) begin
      n_err++; $display("FAIL rd_issue_strobes: got cs=%b rd=%b wr=%b want 1 1 0", bus.mmio_cs, bus.mmio_rd, bus.mmio_wr); end
    n_cmp++; if (bus.mmio_addr !== 21'h000C0) begin n_err++; $display("FAIL rd_issue_addr: got %h want 000c0", bus.mmio_addr); end
    n_cmp++; if (bus.m_ack !== 2'b00) begin n_err++; $display("FAIL rd_early_ack: got %b want 00", bus.m_ack); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL rd_ack: got %b want 01", bus.m_ack); end
    n_cmp++; if (bus.m_rd_data !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_data: got %h want 000000a5", bus.m_rd_data); end
    n_cmp++; if (bus.mmio_cs !== 1'b0) begin n_err++; $display("FAIL rd_ack_cs: got %b want 0", bus.mmio_cs); end
    drop_req(0);
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b00 || state !== 2'd0) begin
      n_err++; $display("FAIL rd_after: got ack=%b state=%0d want 00 0", bus.m_ack, state); end
  endtask

  task automatic test_contention();
    int cnt [2];
    int exp_m;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    do_reset();
    cnt[0] = 0;
    cnt[1] = 0;
    for (int m = 0; m < 2; m++)
      set_req(m, 1'b1, 1'b0, 1'b0, 21'(256*(m+1)), 32'hC000_0000 + 32'(m*256));
    for (int t = 0; t < 6; t++) begin
      exp_m = t % 2;
      ea = 21'(256*(exp_m+1) + cnt[exp_m]);
      ed = 32'hC000_0000 + 32'(exp_m*256 + cnt[exp_m]);
      @(negedge clk);
      n_cmp++; if (grant_id !== 1'(exp_m)) begin n_err++; $display("FAIL cont_grant t%0d: got %0d want %0d", t, grant_id, exp_m); end
      n_cmp++; if (bus.mmio_cs !== 1'b1 || bus.mmio_wr !== 1'b1) begin
        n_err++; $display("FAIL cont_strobe t%0d: got cs=%b wr=%b want 1 1", t, bus.mmio_cs, bus.mmio_wr); end
      n_cmp++; if (bus.mmio_addr !== ea) begin n_err++; $display("FAIL cont_addr t%0d: got %h want %h", t, bus.mmio_addr, ea); end
      n_cmp++; if (bus.mmio_wr_data !== ed) begin n_err++; $display("FAIL cont_wdata t%0d: got %h want %h", t, bus.mmio_wr_data, ed); end
      @(negedge clk);
      n_cmp++; if (bus.m_ack !== (2'b01 << exp_m)) begin
        n_err++; $display("FAIL cont_ack t%0d: got %b want %b", t, bus.m_ack, 2'b01 << exp_m); end
      cnt[exp_m]++;
      if (t == 5) begin
        drop_req(0);
        drop_req(1);
      end else begin
        set_req(exp_m, 1'b1, 1'b0, 1'b0, 21'(256*(exp_m+1) + cnt[exp_m]),
                32'hC000_0000 + 32'(exp_m*256 + cnt[exp_m]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    set_req(1, 1'b0, 1'b1, 1'b1, 21'h000C0, 32'h0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 21'h00300, 32'h0000_0300);
    n_cmp++; if (locked !== 1'b1 || grant_id !== 1'b1) begin
      n_err++; $display("FAIL lock_set: got locked=%b grant=%0d want 1 1", locked, grant_id); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10) begin n_err++; $display("FAIL lock_ack1: got %b want 10", bus.m_ack); end
    n_cmp++; if (bus.m_rd_data !== 32'h0000_00A5) begin n_err++; $display("FAIL lock_rd_data: got %h want 000000a5", bus.m_rd_data); end
    set_req(1, 1'b1, 1'b0, 1'b1, 21'h00080, 32'h0000_0011);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b1 || bus.mmio_addr !== 21'h00080) begin
      n_err++; $display("FAIL lock_issue2: got grant=%0d addr=%h want 1 00080", grant_id, bus.mmio_addr); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10 || locked !== 1'b1) begin
      n_err++; $display("FAIL lock_ack2: got ack=%b locked=%b want 10 1", bus.m_ack, locked); end
    set_req(1, 1'b1, 1'b0, 1'b0, 21'h00084, 32'h0000_0022);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b1 || bus.mmio_addr !== 21'h00084) begin
      n_err++; $display("FAIL lock_issue3: got grant=%0d addr=%h want 1 00084", grant_id, bus.mmio_addr); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10 || locked !== 1'b0) begin
      n_err++; $display("FAIL lock_ack3: got ack=%b locked=%b want 10 0", bus.m_ack, locked); end
    drop_req(1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b0 || bus.mmio_addr !== 21'h00300) begin
      n_err++; $display("FAIL lock_release_grant: got grant=%0d addr=%h want 0 00300", grant_id, bus.mmio_addr); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL lock_release_ack: got %b want 01", bus.m_ack); end
    drop_req(0);
    @(negedge clk);
  endtask

  task automatic test_lock_timeout();
    set_req(1, 1'b1, 1'b0, 1'b1, 21'h00080, 32'h0000_0055);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 21'h00400, 32'h0000_0044);
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10 || locked !== 1'b1) begin
      n_err++; $display("FAIL tmo_ack1: got ack=%b locked=%b want 10 1", bus.m_ack, locked); end
    drop_req(1);
    for (int i = 1; i <= LOCK_TMO; i++) begin
      @(negedge clk);
      n_cmp++; if (locked !== 1'b1 || state !== 2'd0 || bus.m_ack !== 2'b00) begin
        n_err++; $display("FAIL tmo_hold idle%0d: got locked=%b state=%0d ack=%b want 1 0 00", i, locked, state, bus.m_ack); end
    end
    @(negedge clk);
    n_cmp++; if (locked !== 1'b0 || state !== 2'd0) begin
      n_err++; $display("FAIL tmo_release: got locked=%b state=%0d want 0 0", locked, state); end
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b0 || bus.mmio_addr !== 21'h00400) begin
      n_err++; $display("FAIL tmo_grant: got grant=%0d addr=%h want 0 00400", grant_id, bus.mmio_addr); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL tmo_ack0: got %b want 01", bus.m_ack); end
    drop_req(0);
    @(negedge clk);
  endtask

  task automatic test_illegal_empty();
    int cs0;
    set_req(0, 1'b1, 1'b1, 1'b0, 21'h00080, 32'h0000_0003);
    @(negedge clk);
    n_cmp++; if (bus.mmio_cs !== 1'b1 || bus.mmio_wr !== 1'b1 || bus.mmio_rd !== 1'b0) begin
      n_err++; $display("FAIL ill_strobes: got cs=%b wr=%b rd=%b want 1 1 0", bus.mmio_cs, bus.mmio_wr, bus.mmio_rd); end
    n_cmp++; if (bus.mmio_wr_data !== 32'h0000_0003) begin n_err++; $display("FAIL ill_wdata: got %h want 00000003", bus.mmio_wr_data); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b01) begin n_err++; $display("FAIL ill_ack: got %b want 01", bus.m_ack); end
    n_cmp++; if (bus.m_rd_data !== 32'h0) begin n_err++; $display("FAIL ill_rd_data: got %h want 0", bus.m_rd_data); end
    n_cmp++; if (led !== 8'h03) begin n_err++; $display("FAIL ill_led: got %h want 03", led); end
    drop_req(0);
    @(negedge clk);
    cs0 = cs_cnt;
    set_req(1, 1'b0, 1'b0, 1'b0, 21'h00084, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.mmio_cs !== 1'b0 || state !== 2'd1) begin
      n_err++; $display("FAIL empty_issue: got cs=%b state=%0d want 0 1", bus.mmio_cs, state); end
    drop_req(1);
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10) begin n_err++; $display("FAIL empty_ack: got %b want 10", bus.m_ack); end
    n_cmp++; if (bus.m_rd_data !== 32'h0) begin n_err++; $display("FAIL empty_rd_data: got %h want 0", bus.m_rd_data); end
    @(negedge clk);
    n_cmp++; if (cs_cnt !== cs0 || state !== 2'd0) begin
      n_err++; $display("FAIL empty_nobus: got cs_cycles=%0d state=%0d want %0d 0", cs_cnt - cs0, state, 0); end
  endtask

  task automatic test_reset_in_issue();
    set_req(0, 1'b0, 1'b1, 1'b0, 21'h000C0, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.mmio_cs !== 1'b1) begin n_err++; $display("FAIL rsti_pre_cs: got %b want 1", bus.mmio_cs); end
    set_req(1, 1'b1, 1'b0, 1'b0, 21'h00500, 32'h0000_0077);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.mmio_cs !== 1'b0 || bus.mmio_rd !== 1'b0 || bus.mmio_addr !== 21'h0) begin
      n_err++; $display("FAIL rsti_bus: got cs=%b rd=%b addr=%h want 0 0 0", bus.mmio_cs, bus.mmio_rd, bus.mmio_addr); end
    n_cmp++; if (state !== 2'd0 || locked !== 1'b0) begin
      n_err++; $display("FAIL rsti_state: got state=%0d locked=%b want 0 0", state, locked); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b00) begin n_err++; $display("FAIL rsti_no_ack: got %b want 00", bus.m_ack); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b0 || bus.mmio_addr !== 21'h000C0 || bus.mmio_rd !== 1'b1) begin
      n_err++; $display("FAIL rsti_regrant: got grant=%0d addr=%h rd=%b want 0 000c0 1", grant_id, bus.mmio_addr, bus.mmio_rd); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b01 || bus.m_rd_data !== 32'h0000_00A5) begin
      n_err++; $display("FAIL rsti_ack0: got ack=%b data=%h want 01 000000a5", bus.m_ack, bus.m_rd_data); end
    drop_req(0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant_id !== 1'b1 || bus.mmio_addr !== 21'h00500) begin
      n_err++; $display("FAIL rsti_next: got grant=%0d addr=%h want 1 00500", grant_id, bus.mmio_addr); end
    @(negedge clk);
    n_cmp++; if (bus.m_ack !== 2'b10) begin n_err++; $display("FAIL rsti_ack1: got %b want 10", bus.m_ack); end
    drop_req(1);
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_illegal_empty();
    test_reset_in_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
